// File: rtl/ysyx_22051013_mem_arbiter_if.sv
// Signal bundle between the I/D requesters, the arbiter and the shared memory port.
// The arbiter binds the master modport (it drives the shared port); the core and memory bind slave.
interface ysyx_22051013_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic [2:0]            i_size;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_done;
    logic                  i_err;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic [2:0]            d_size;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_done;
    logic                  d_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [2:0]            mem_size;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        input  i_req, i_addr, i_size,
        output i_rdata, i_done, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb, d_size,
        output d_rdata, d_done, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_size,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output i_req, i_addr, i_size,
        input  i_rdata, i_done, i_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb, d_size,
        input  d_rdata, d_done, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_size,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/ysyx_22051013_mem_arbiter.sv
// Round-robin I/D arbiter onto one registered memory port, with a watchdog that times out hung accesses.
// Grant -> mem_req 1 cycle; ack -> done 1 cycle; one RESP cycle with no grant so requesters can drop req.
module ysyx_22051013_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22051013_mem_arbiter_if.master    bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    logic                last_grant_d;
    logic [7:0]          wdog;

    logic                grant_d;
    logic                grant_we;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_wdata;
    logic [STRB_W-1:0]   grant_wstrb;
    logic [2:0]          grant_size;
    logic [DATA_W-1:0]   ack_rdata;
    logic                finish;

    // On a tie the side that did not win last time gets the port; reset leaves I as last so D wins first.
    always_comb begin
        grant_d     = bus.d_req && (!bus.i_req || !last_grant_d);
        grant_we    = grant_d && bus.d_we;
        grant_addr  = grant_d ? bus.d_addr : bus.i_addr;
        grant_wdata = grant_d ? bus.d_wdata : '0;
        grant_wstrb = grant_we ? bus.d_wstrb : '0;
        grant_size  = grant_d ? bus.d_size : bus.i_size;
        ack_rdata   = bus.mem_we ? '0 : bus.mem_rdata;
        finish      = bus.mem_ack || (wdog == WDOG_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant_d  <= 1'b0;
            wdog          <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.mem_size  <= '0;
            bus.i_done    <= 1'b0;
            bus.i_err     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_done    <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= grant_we;
                        bus.mem_addr  <= grant_addr;
                        bus.mem_wdata <= grant_wdata;
                        bus.mem_wstrb <= grant_wstrb;
                        bus.mem_size  <= grant_size;
                        last_grant_d  <= grant_d;
                        wdog          <= '0;
                        state         <= grant_d ? BUSY_D : BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack arriving on the watchdog's last cycle still counts as a normal completion.
                    if (finish) begin
                        bus.mem_req <= 1'b0;
                        if (state == BUSY_I) begin
                            bus.i_done  <= 1'b1;
                            bus.i_err   <= !bus.mem_ack;
                            bus.i_rdata <= bus.mem_ack ? ack_rdata : '0;
                        end else begin
                            bus.d_done  <= 1'b1;
                            bus.d_err   <= !bus.mem_ack;
                            bus.d_rdata <= bus.mem_ack ? ack_rdata : '0;
                        end
                        state <= RESP;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                RESP: begin
                    wdog  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// Directed bench for the I/D memory arbiter; drives at negedge/after posedge, samples at negedge.
module tb_ysyx_22051013_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ysyx_22051013_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ysyx_22051013_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Returns at the first negedge with mem_req high, or records a failure after 12 cycles.
    task automatic wait_mem_req(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < 12);
        check(tag, 64'(bus.mem_req), 64'd1);
    endtask

    task automatic pulse_ack(input logic [63:0] data);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = '0; bus.i_size = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.d_wstrb = '0; bus.d_size = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 64'(bus.mem_req), 0);
        check("rst_i_done",  64'(bus.i_done),  0);
        check("rst_d_done",  64'(bus.d_done),  0);
        check("rst_i_rdata", bus.i_rdata,      0);
        check("rst_mem_we",  64'(bus.mem_we),  0);

        // I fetch alone, ack on the 4th cycle of mem_req
        bus.i_req = 1; bus.i_addr = 64'h8000_0000; bus.i_size = 3'd2;
        @(negedge clk);
        check("t1_mem_req",   64'(bus.mem_req),   1);
        check("t1_mem_addr",  bus.mem_addr,       64'h8000_0000);
        check("t1_mem_we",    64'(bus.mem_we),    0);
        check("t1_mem_wstrb", 64'(bus.mem_wstrb), 0);
        check("t1_mem_size",  64'(bus.mem_size),  2);
        @(negedge clk);
        @(negedge clk);
        check("t1_hold_req",  64'(bus.mem_req),   1);
        check("t1_no_done",   64'(bus.i_done),    0);
        @(negedge clk);
        pulse_ack(64'h1122_3344_5566_7788);
        @(negedge clk);
        check("t1_i_done",    64'(bus.i_done),    1);
        check("t1_i_rdata",   bus.i_rdata,        64'h1122_3344_5566_7788);
        check("t1_i_err",     64'(bus.i_err),     0);
        check("t1_req_low",   64'(bus.mem_req),   0);
        check("t1_d_done",    64'(bus.d_done),    0);
        bus.i_req = 0;
        @(negedge clk);
        check("t1_done_pulse", 64'(bus.i_done),   0);
        check("t1_rdata_held", bus.i_rdata,       64'h1122_3344_5566_7788);

        // D byte store
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h8000_0010;
        bus.d_wdata = 64'hAB; bus.d_wstrb = 8'h01; bus.d_size = 3'd0;
        @(negedge clk);
        check("t2_mem_req",   64'(bus.mem_req),   1);
        check("t2_mem_we",    64'(bus.mem_we),    1);
        check("t2_mem_wstrb", 64'(bus.mem_wstrb), 64'h01);
        check("t2_mem_addr",  bus.mem_addr,       64'h8000_0010);
        check("t2_mem_wdata", bus.mem_wdata,      64'hAB);
        check("t2_mem_size",  64'(bus.mem_size),  0);
        pulse_ack(64'hDEAD_BEEF);
        @(negedge clk);
        check("t2_d_done",    64'(bus.d_done),    1);
        check("t2_d_rdata",   bus.d_rdata,        0);
        check("t2_d_err",     64'(bus.d_err),     0);
        check("t2_i_done",    64'(bus.i_done),    0);
        bus.d_req = 0; bus.d_we = 0;

        // Both requesting from reset: D,I,D,I
        @(negedge clk);
        rst = 1'b1;
        bus.i_req = 1; bus.i_addr = 64'h1000;
        bus.d_req = 1; bus.d_addr = 64'h2000; bus.d_wstrb = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_mem_req("tie_req");
            check("tie_owner", bus.mem_addr, (k % 2 == 0) ? 64'h2000 : 64'h1000);
            pulse_ack(64'(k + 1));
            @(negedge clk);
            check("tie_d_done", 64'(bus.d_done), 64'(k % 2 == 0));
            check("tie_i_done", 64'(bus.i_done), 64'(k % 2 == 1));
            @(negedge clk);
            check("tie_resp_gap", 64'(bus.mem_req), 0);
        end
        bus.i_req = 0; bus.d_req = 0;
        @(negedge clk);
        check("tie_stop",     64'(bus.mem_req),   0);
        check("tie_i_rdata",  bus.i_rdata,        64'd4);
        check("tie_d_rdata",  bus.d_rdata,        64'd3);

        // Timeout with TIMEOUT=4: mem_req high exactly 4 cycles
        bus.i_req = 1; bus.i_addr = 64'h3000;
        wait_mem_req("to_req");
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check("to_hold", 64'(bus.mem_req), 1);
        end
        @(negedge clk);
        check("to_req_low",   64'(bus.mem_req),   0);
        check("to_i_done",    64'(bus.i_done),    1);
        check("to_i_err",     64'(bus.i_err),     1);
        check("to_i_rdata",   bus.i_rdata,        0);
        bus.i_req = 0;
        @(negedge clk);
        check("to_done_pulse", 64'(bus.i_done),   0);

        // Ack on the watchdog's last cycle wins
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h4000;
        wait_mem_req("race_req");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("race_req_4th", 64'(bus.mem_req),   1);
        pulse_ack(64'h0F0E_0D0C_0B0A_0908);
        @(negedge clk);
        check("race_d_done",  64'(bus.d_done),    1);
        check("race_d_err",   64'(bus.d_err),     0);
        check("race_d_rdata", bus.d_rdata,        64'h0F0E_0D0C_0B0A_0908);
        check("race_i_err_held", 64'(bus.i_err),  1);
        bus.d_req = 0;

        // Reset while BUSY_D abandons the access
        @(negedge clk);
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h5000;
        bus.d_wdata = 64'h55; bus.d_wstrb = 8'hFF; bus.d_size = 3'd3;
        wait_mem_req("rb_req");
        rst = 1'b1; bus.d_req = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rb_mem_req",   64'(bus.mem_req),   0);
        check("rb_d_done",    64'(bus.d_done),    0);
        check("rb_mem_we",    64'(bus.mem_we),    0);
        check("rb_d_rdata",   bus.d_rdata,        0);
        check("rb_i_err",     64'(bus.i_err),     0);
        pulse_ack(64'h77);
        @(negedge clk);
        check("rb_late_ack_done", 64'(bus.d_done), 0);
        check("rb_late_ack_req",  64'(bus.mem_req), 0);
        check("rb_late_ack_data", bus.d_rdata,     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
